// File: rtl/imem_loader.sv
// imem_loader -- streams bytes from an upstream source into instruction memory.
//
// Bytes are packed little-endian into 32-bit words; each completed word is
// written with a one-cycle wr_en strobe at BASE_ADDR + 4*index. The CPU is
// held in reset (cpu_hold) until the whole image has been written.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the image and is compared against
//   the running XOR of all image bytes; a difference sets the sticky err flag.
//   When undefined, no checksum byte is consumed and err is tied low.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   start            one-cycle load request, honoured only in IDLE or DONE
//   word_count       number of words to load, captured with start
//   byte_valid/data  upstream byte stream
//   byte_ready       loader accepts a byte this cycle
//   wr_en/addr/data  instruction-memory write port
//   busy, done       load in progress / sticky completion flag
//   cpu_hold         high in every state except DONE
//   err              sticky checksum-mismatch flag
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

    localparam logic [CNT_W:0] ONE_EXT = (CNT_W+1)'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      lo_bytes;   // first three bytes of the word in flight
    logic             last_word;

    // Extended by one bit so index+1 cannot overflow at the maximum count.
    assign last_word = ({1'b0, word_idx} + ONE_EXT) >= {1'b0, cnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE, DONE: begin
                done     = (state == DONE);
                cpu_hold = (state != DONE);
                if (start) state_nxt = (word_count != '0) ? RECV : DONE;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (!last_word) state_nxt = RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                else            state_nxt = CHECK;
`else
                else            state_nxt = DONE;
`endif
            end
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address and data are registered as the last byte arrives, so they are
    // stable throughout WRITE and hold their values afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            lo_bytes <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt      <= word_count;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_data <= {byte_data, lo_bytes};
                            wr_addr <= BASE_ADDR + (32'(word_idx) << 2);
                        end else begin
                            lo_bytes <= {byte_data, lo_bytes[23:8]};
                        end
                    end
                end
                WRITE: begin
                    if (!last_word) word_idx <= word_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    csum  <= '0;
                    err_q <= 1'b0;
                end
                RECV:  if (byte_valid) csum  <= csum ^ byte_data;
                CHECK: if (byte_valid) err_q <= (byte_data != csum);
                default: ;
            endcase
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int CNT_W = 9;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] word_count = '0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = '0;
    logic             byte_ready, wr_en, busy, done, cpu_hold, err;
    logic [31:0]      wr_addr, wr_data;

    int errors = 0;
    int checks = 0;

    // observed writes
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          br_bad = 0;
    // reference image (words) and expectations
    logic [31:0] wq[$];
    logic        exp_err;

    imem_loader #(.BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .cpu_hold(cpu_hold), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (byte_ready) br_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start = 1'b1; word_count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [7:0] img_byte(input int k);
        logic [31:0] w;
        w = wq[k >> 2];
        return 8'(w >> (8 * (k & 3)));
    endfunction

    function automatic logic [7:0] img_xor();
        logic [7:0] x = '0;
        for (int k = 0; k < 4 * wq.size(); k++) x ^= img_byte(k);
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        byte_valid = 1'b1; byte_data = b;
        n = 0;
        @(negedge clk);
        while (byte_ready !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) chk("byte_ready_timeout", {31'b0, byte_ready}, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int maxgap);
        for (int k = from; k < to; k++) send_byte(img_byte(k), $urandom_range(0, maxgap));
    endtask

    task automatic send_csum(input bit bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(img_xor() ^ {7'b0, bad}, $urandom_range(0, 2));
        exp_err = bad;
`else
        exp_err = 1'b0;
`endif
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        chk("done", {31'b0, done}, 32'd1);
    endtask

    // Compare observed write stream against the image: word i at BASE+4*i.
    task automatic check_image(input string tag);
        chk({tag, "_nwrites"}, wa_q.size(), wq.size());
        for (int i = 0; i < wq.size() && i < wa_q.size(); i++) begin
            chk({tag, "_addr"}, wa_q[i], BASE + 32'(4 * i));
            chk({tag, "_data"}, wd_q[i], wq[i]);
        end
        chk({tag, "_br_in_write"}, br_bad, 0);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        if (wq.size() > 0) chk({tag, "_hold_data"}, wr_data, wq[wq.size()-1]);
    endtask

    task automatic clear_obs();
        wa_q.delete(); wd_q.delete(); br_bad = 0;
    endtask

    task automatic run_image(input string tag, input int maxgap, input bit bad);
        clear_obs();
        do_start(wq.size());
        send_range(0, 4 * wq.size(), maxgap);
        send_csum(bad);
        wait_done();
        check_image(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, wr_addr, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
    endtask

    initial begin
        // reset
        #3 rst = 1'b0;
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // zero-length load: straight to DONE, no writes, no bytes taken
        clear_obs();
        @(negedge clk);
        chk("zero_pre_done", {31'b0, done}, 32'd0);
        do_start(0);
        @(negedge clk);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_br", {31'b0, byte_ready}, 32'd0);
        chk("zero_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        repeat (3) @(negedge clk);
        chk("zero_nwrites", wa_q.size(), 0);

        // single word 0x00000013
        wq = '{32'h0000_0013};
        run_image("one", 0, 1'b0);

        // three words with gaps on byte_valid
        wq = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        run_image("three", 3, 1'b0);

        // start while busy is ignored; stalled input holds state
        wq = '{32'hDEAD_BEEF, 32'h1234_5678};
        clear_obs();
        do_start(2);
        send_range(0, 1, 0);
        start = 1'b1; word_count = CNT_W'(5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("stall_busy", {31'b0, busy}, 32'd1);
        chk("stall_nwrites", wa_q.size(), 0);
        send_range(1, 8, 1);
        send_csum(1'b0);
        wait_done();
        check_image("ignore_start");

        // reset mid-load after 2 bytes of word 1
        wq = '{32'h0050_0093, 32'h00A0_0113};
        clear_obs();
        do_start(2);
        send_range(0, 6, 1);
        #2 rst = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_nwrites", wa_q.size(), 1);
        wq = '{32'h00A0_0113};
        run_image("reload", 1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wq = '{32'h0000_0013};
        run_image("csum_good", 0, 1'b0);
        run_image("csum_bad", 0, 1'b1);
`endif

        // randomized images
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 6);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            run_image("rand", 3, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-002 SHALL have parameter CNT_W, default 9, width of word_count (maximum load 2^CNT_W-1 words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle load request; sampled only in IDLE or DONE.
REQ-006 SHALL have port word_count  input  CNT_W  number of 32-bit words to load; captured on accepted start.
REQ-007 SHALL have port byte_valid  input  1  upstream byte available.
REQ-008 SHALL have port byte_data  input  8  upstream byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 SHALL have port wr_addr  output  32  byte address of the word being written.
REQ-012 SHALL have port wr_data  output  32  assembled instruction word.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  sticky load-complete flag.
REQ-015 SHALL have port cpu_hold  output  1  holds CPU (PC/register file) in reset while asserted.
REQ-016 SHALL have port err  output  1  sticky checksum-mismatch flag.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-018 Byte transfer SHALL occur only on a cycle with byte_valid && byte_ready.
REQ-019 byte_ready SHALL be 1 only in RECV and CHECK; 0 in IDLE, WRITE, DONE.
REQ-020 IDLE/DONE + start: word_count != 0 -> RECV, word index 0, byte index 0, clear done/err; word_count == 0 -> DONE, no write.
REQ-021 start while busy SHALL be ignored.
REQ-022 RECV SHALL pack bytes little-endian: byte 0 -> wr_data[7:0], byte 3 -> wr_data[31:24]; after 4th transfer -> WRITE.
REQ-023 WRITE SHALL assert wr_en exactly one cycle, wr_addr = BASE_ADDR + 4*index (32-bit wrap), wr_data stable that cycle.
REQ-024 After WRITE: index+1 < word_count -> RECV; else -> CHECK (macro defined) or DONE (macro undefined).
REQ-025 wr_addr and wr_data SHALL hold last values outside WRITE; wr_en 0 outside WRITE.
REQ-026 busy SHALL be 1 in RECV, WRITE, CHECK; done 1 only in DONE.
REQ-027 cpu_hold SHALL be 1 in every state except DONE.
REQ-028 Stalled byte_valid SHALL hold state indefinitely; no timeout.
REQ-029 Upstream byte latency: one word SHALL take at least 5 cycles (4 transfers + WRITE).

Reset
REQ-030 rst low SHALL asynchronously force IDLE, indices 0, wr_en 0, wr_addr 0, wr_data 0, byte_ready 0, busy 0, done 0, err 0, cpu_hold 1.
REQ-031 Reset mid-load SHALL abort without further writes; partially received word discarded.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN defined: loader SHALL keep running XOR of all data bytes; in CHECK accept one byte, set err if it differs from XOR, then -> DONE.
REQ-033 Macro undefined: no CHECK state entered, no checksum byte consumed, err tied 0.

Verification
REQ-034 start, word_count=1, bytes 13,00,00,00 -> single wr_en, wr_addr=0x0, wr_data=0x00000013, then done=1, cpu_hold=0.
REQ-035 word_count=3, bytes for 0x00500093, 0x00A00113, 0x002081B3 with valid gaps -> writes at 0x0,0x4,0x8 in order, byte_ready=0 during each WRITE.
REQ-036 word_count=0 -> DONE next cycle, wr_en never asserted, byte_ready stays 0.
REQ-037 Reset asserted after 2 bytes of word 1 -> outputs at reset values immediately, no wr_en; fresh start reloads correctly from 0x0.
REQ-038 CHECKSUM_EN, word 0x00000013 + checksum 0x13 -> err=0; checksum 0x12 -> err=1, done=1.
REQ-039 start pulsed during RECV -> ignored, word index and byte count unchanged.
